cu_exec_pipe: RTL

- Parametrised next-generation compute unit for the processor core.
- Merges the register file, ALU, shifter and a pipelined multiplier into one issue/writeback pipeline with a valid/ready handshake to the program sequencer (PS).
- Adds per-register scoreboarding, a writeback-slot reservation and registered flags, so PS can issue back-to-back ops without tracking unit latencies itself.

---
 rtl/cu_exec_pipe.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cu_exec_pipe.sv
// cu_exec_pipe: compute-unit issue/writeback pipeline (RF, ALU, SHF, pipelined MUL, scoreboard).
// Optional writeback-to-operand bypass: define CU_FWD_EN.
module cu_exec_pipe #(
  parameter int RF_DATASIZE   = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int MUL_LATENCY   = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ps_cu_valid,
  output logic                     cu_ps_ready,
  input  logic [1:0]               ps_cu_cls,
  input  logic [2:0]               ps_cu_fn,
  input  logic [ADDRESS_WIDTH-1:0] ps_rf_xA,
  input  logic [ADDRESS_WIDTH-1:0] ps_rf_yA,
  input  logic [ADDRESS_WIDTH-1:0] ps_rf_wrtA,
  input  logic [RF_DATASIZE-1:0]   dm_xb_dmD,
  output logic [RF_DATASIZE-1:0]   xb_cu_rx,
  output logic                     cu_ps_zf,
  output logic                     cu_ps_nf,
  output logic                     cu_ps_vf,
  output logic                     cu_ps_busy
);

  localparam int W    = RF_DATASIZE;
  localparam int AW   = ADDRESS_WIDTH;
  localparam int NREG = 1 << ADDRESS_WIDTH;
  localparam int L    = MUL_LATENCY;
  localparam int SW   = $clog2(RF_DATASIZE);
  localparam logic [SW:0] WSH = SW'(0) + (SW+1)'(W);

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b01;
  localparam logic [1:0] CLS_SHF = 2'b10;
  localparam logic [1:0] CLS_DM  = 2'b11;

  logic [W-1:0]    rf_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  // resv_q[k]: a MUL writes back at the (k+1)-th upcoming edge; doubles as the MUL pipe valid chain
  logic [L-1:0]    resv_q, resv_d;

  logic            wb1_v_q, wb1_v_d;
  logic [AW-1:0]   wb1_dst_q, wb1_dst_d;
  logic [W-1:0]    wb1_res_q, wb1_res_d;
  logic            wb1_upd_q, wb1_upd_d;
  logic            wb1_vf_q, wb1_vf_d;

  logic [W-1:0]    m0_a_q, m0_b_q;
  logic [2:0]      m0_fn_q;
  logic [AW-1:0]   m0_dst_q;
  logic [W-1:0]    mres_q [L-1];
  logic [AW-1:0]   mdst_q [L-1];
  logic            mvf_q  [L-1];

  logic            zf_q, zf_d, nf_q, nf_d, vf_q, vf_d;

  logic            wb_en, wb_upd, wb_vf;
  logic [AW-1:0]   wb_dst;
  logic [W-1:0]    wb_data;

  logic [W-1:0]    rx, ry;
  logic            stall_x, stall_y, hazard, slot_busy, accept;
  logic [W-1:0]    ex_res;
  logic            ex_vf;

  logic [W-1:0]    alu_sum, alu_dif;
  logic [2*W-1:0]  lsl_w;
  logic [SW-1:0]   shamt;

  logic signed [2*W-1:0] p_s;
  logic [W-1:0]    p_ul;
  logic [W-1:0]    mul_res;
  logic            mul_vf;

  // Single write port: the 1-cycle stage and the MUL tail never collide thanks to the reservation
  assign wb_en = wb1_v_q | resv_q[0];

  always_comb begin
    wb_dst  = mdst_q[L-2];
    wb_data = mres_q[L-2];
    wb_upd  = 1'b1;
    wb_vf   = mvf_q[L-2];
    if (wb1_v_q) begin
      wb_dst  = wb1_dst_q;
      wb_data = wb1_res_q;
      wb_upd  = wb1_upd_q;
      wb_vf   = wb1_vf_q;
    end
  end

`ifdef CU_FWD_EN
  logic fwd_x, fwd_y;
  assign fwd_x   = wb_en && (wb_dst == ps_rf_xA);
  assign fwd_y   = wb_en && (wb_dst == ps_rf_yA);
  assign rx      = fwd_x ? wb_data : rf_q[ps_rf_xA];
  assign ry      = fwd_y ? wb_data : rf_q[ps_rf_yA];
  assign stall_x = pend_q[ps_rf_xA] & ~fwd_x;
  assign stall_y = pend_q[ps_rf_yA] & ~fwd_y;
`else
  assign rx      = rf_q[ps_rf_xA];
  assign ry      = rf_q[ps_rf_yA];
  assign stall_x = pend_q[ps_rf_xA];
  assign stall_y = pend_q[ps_rf_yA];
`endif

  assign xb_cu_rx  = rf_q[ps_rf_xA];
  assign hazard    = pend_q[ps_rf_wrtA] | ((ps_cu_cls != CLS_DM) & (stall_x | stall_y));
  assign slot_busy = (ps_cu_cls != CLS_MUL) & resv_q[1];
  assign cu_ps_ready = reset_n & ~hazard & ~slot_busy;
  assign accept      = ps_cu_valid & cu_ps_ready;

  assign alu_sum = rx + ry;
  assign alu_dif = rx - ry;
  assign shamt   = ry[SW-1:0];
  assign lsl_w   = {{W{1'b0}}, rx} << shamt;

  always_comb begin
    ex_res = '0;
    ex_vf  = 1'b0;
    unique case (ps_cu_cls)
      CLS_ALU: begin
        unique case (ps_cu_fn)
          3'b000: begin
            ex_res = alu_sum;
            ex_vf  = (rx[W-1] == ry[W-1]) & (alu_sum[W-1] != rx[W-1]);
          end
          3'b001: begin
            ex_res = alu_dif;
            ex_vf  = (rx[W-1] != ry[W-1]) & (alu_dif[W-1] != rx[W-1]);
          end
          3'b010:  ex_res = rx & ry;
          3'b011:  ex_res = rx | ry;
          3'b100:  ex_res = rx ^ ry;
          3'b101:  ex_res = rx;
          default: ex_res = '0;
        endcase
      end
      CLS_SHF: begin
        unique case (ps_cu_fn)
          3'b000: begin
            ex_res = lsl_w[W-1:0];
            ex_vf  = |lsl_w[2*W-1:W];
          end
          3'b001:  ex_res = rx >> shamt;
          3'b010:  ex_res = $unsigned($signed(rx) >>> shamt);
          3'b011:  ex_res = (rx << shamt) | (rx >> (WSH - {1'b0, shamt}));
          default: ex_res = rx;
        endcase
      end
      CLS_DM:  ex_res = dm_xb_dmD;
      default: ex_res = '0;
    endcase
  end

  assign p_s  = $signed({{W{m0_a_q[W-1]}}, m0_a_q}) * $signed({{W{m0_b_q[W-1]}}, m0_b_q});
  assign p_ul = m0_a_q * m0_b_q;

  always_comb begin
    mul_res = '0;
    mul_vf  = 1'b0;
    unique case (m0_fn_q)
      3'b000: mul_res = p_ul;
      3'b001: begin
        mul_res = p_s[W-1:0];
        mul_vf  = p_s[2*W-1:W] != {W{p_s[W-1]}};
      end
      3'b010:  mul_res = p_s[2*W-1:W];
      default: mul_res = '0;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (wb_en) pend_d[wb_dst] = 1'b0;
    if (accept) pend_d[ps_rf_wrtA] = 1'b1;

    resv_d = resv_q >> 1;
    if (accept && (ps_cu_cls == CLS_MUL)) resv_d[L-1] = 1'b1;

    wb1_v_d   = accept && (ps_cu_cls != CLS_MUL);
    wb1_dst_d = ps_rf_wrtA;
    wb1_res_d = ex_res;
    wb1_upd_d = ps_cu_cls != CLS_DM;
    wb1_vf_d  = ex_vf;

    zf_d = zf_q;
    nf_d = nf_q;
    vf_d = vf_q;
    if (wb_en && wb_upd) begin
      zf_d = wb_data == '0;
      nf_d = wb_data[W-1];
      vf_d = wb_vf;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      pend_q    <= '0;
      resv_q    <= '0;
      wb1_v_q   <= 1'b0;
      wb1_dst_q <= '0;
      wb1_res_q <= '0;
      wb1_upd_q <= 1'b0;
      wb1_vf_q  <= 1'b0;
      m0_a_q    <= '0;
      m0_b_q    <= '0;
      m0_fn_q   <= '0;
      m0_dst_q  <= '0;
      for (int j = 0; j < L-1; j++) begin
        mres_q[j] <= '0;
        mdst_q[j] <= '0;
        mvf_q[j]  <= 1'b0;
      end
      zf_q <= 1'b0;
      nf_q <= 1'b0;
      vf_q <= 1'b0;
    end else begin
      if (wb_en) rf_q[wb_dst] <= wb_data;
      pend_q    <= pend_d;
      resv_q    <= resv_d;
      wb1_v_q   <= wb1_v_d;
      wb1_dst_q <= wb1_dst_d;
      wb1_res_q <= wb1_res_d;
      wb1_upd_q <= wb1_upd_d;
      wb1_vf_q  <= wb1_vf_d;
      if (accept && (ps_cu_cls == CLS_MUL)) begin
        m0_a_q   <= rx;
        m0_b_q   <= ry;
        m0_fn_q  <= ps_cu_fn;
        m0_dst_q <= ps_rf_wrtA;
      end
      mres_q[0] <= mul_res;
      mdst_q[0] <= m0_dst_q;
      mvf_q[0]  <= mul_vf;
      for (int j = 1; j < L-1; j++) begin
        mres_q[j] <= mres_q[j-1];
        mdst_q[j] <= mdst_q[j-1];
        mvf_q[j]  <= mvf_q[j-1];
      end
      zf_q <= zf_d;
      nf_q <= nf_d;
      vf_q <= vf_d;
    end
  end

  assign cu_ps_zf   = zf_q;
  assign cu_ps_nf   = nf_q;
  assign cu_ps_vf   = vf_q;
  assign cu_ps_busy = |pend_q;

endmodule
